// File: rtl/phase_to_rgb_pipe_if.sv
// ============================================================================
// Module   : phase_to_rgb_pipe_if
// Brief    : Stream handshake bundle for the phase-to-RGB converter.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface phase_to_rgb_pipe_if #(
  parameter int PHASE_W = 16,
  parameter int COLOR_W = 8
);
  logic               in_valid;
  logic               in_ready;
  logic [PHASE_W-1:0] in_phase;
  logic [COLOR_W-1:0] in_mag;
  logic               in_last;
  logic [PHASE_W-1:0] offset_in;
  logic               offset_ld;
  logic               out_valid;
  logic               out_ready;
  logic [COLOR_W-1:0] out_red;
  logic [COLOR_W-1:0] out_green;
  logic [COLOR_W-1:0] out_blue;
  logic               out_last;

  modport master (
    output in_valid, in_phase, in_mag, in_last, offset_in, offset_ld, out_ready,
    input  in_ready, out_valid, out_red, out_green, out_blue, out_last
  );

  modport slave (
    input  in_valid, in_phase, in_mag, in_last, offset_in, offset_ld, out_ready,
    output in_ready, out_valid, out_red, out_green, out_blue, out_last
  );
endinterface

`default_nettype wire

// File: rtl/phase_to_rgb_pipe.sv
// ============================================================================
// Module   : phase_to_rgb_pipe
// Brief    : 3-stage phase + magnitude to RGB converter, exact six-sector hue wheel.
// Revision : 1.0
// ============================================================================
`default_nettype none

module phase_to_rgb_pipe #(
  parameter int                 PHASE_W    = 16,
  parameter int                 COLOR_W    = 8,
  parameter logic [PHASE_W-1:0] OFFSET_RST = {1'b1, {(PHASE_W-1){1'b0}}}
) (
  input  wire                 clk,
  input  wire                 rst_n,
  phase_to_rgb_pipe_if.slave  bus
);

  typedef logic [COLOR_W-1:0] col_t;
  typedef logic [PHASE_W+2:0] prod6_t;
  typedef logic [2*COLOR_W:0] prodm_t;

  localparam col_t c_max = {COLOR_W{1'b1}};

  // out = c*(mag+1) >> COLOR_W keeps both endpoints exact
  function automatic col_t scale(input col_t c, input col_t m);
    prodm_t prod;
    prod = prodm_t'(c) * (prodm_t'(m) + prodm_t'(1));
    return col_t'(prod >> COLOR_W);
  endfunction

  logic [PHASE_W-1:0] r_offset;

  logic               r_v1;
  logic [PHASE_W-1:0] r_hue;
  col_t               r_mag1;
  logic               r_last1;

  logic               r_v2;
  col_t               r_red2;
  col_t               r_green2;
  col_t               r_blue2;
  col_t               r_mag2;
  logic               r_last2;

  logic               r_v3;
  col_t               r_red3;
  col_t               r_green3;
  col_t               r_blue3;
  logic               r_last3;

  logic               w_advance;
  prod6_t             w_p;
  logic [2:0]         w_sector;
  logic [PHASE_W-1:0] w_frac;
  col_t               w_x;
  col_t               w_red;
  col_t               w_green;
  col_t               w_blue;

  assign w_advance = !r_v3 || bus.out_ready;

  assign w_p      = prod6_t'(r_hue) * prod6_t'(6);
  assign w_sector = 3'(w_p >> PHASE_W);
  assign w_frac   = PHASE_W'(w_p);
  assign w_x      = col_t'(w_frac >> (PHASE_W - COLOR_W));

  always_comb begin
    w_red   = '0;
    w_green = '0;
    w_blue  = '0;
    case (w_sector)
      3'd0: begin w_red = c_max;       w_green = w_x;         w_blue = '0;          end
      3'd1: begin w_red = c_max - w_x; w_green = c_max;       w_blue = '0;          end
      3'd2: begin w_red = '0;          w_green = c_max;       w_blue = w_x;         end
      3'd3: begin w_red = '0;          w_green = c_max - w_x; w_blue = c_max;       end
      3'd4: begin w_red = w_x;         w_green = '0;          w_blue = c_max;       end
      3'd5: begin w_red = c_max;       w_green = '0;          w_blue = c_max - w_x; end
      default: begin w_red = '0; w_green = '0; w_blue = '0; end
    endcase
  end

  // Offset loads regardless of stalls; a sample taken this edge still sees the old value
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_offset <= OFFSET_RST;
    end else if (bus.offset_ld) begin
      r_offset <= bus.offset_in;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_v1     <= 1'b0;
      r_hue    <= '0;
      r_mag1   <= '0;
      r_last1  <= 1'b0;
      r_v2     <= 1'b0;
      r_red2   <= '0;
      r_green2 <= '0;
      r_blue2  <= '0;
      r_mag2   <= '0;
      r_last2  <= 1'b0;
      r_v3     <= 1'b0;
      r_red3   <= '0;
      r_green3 <= '0;
      r_blue3  <= '0;
      r_last3  <= 1'b0;
    end else if (w_advance) begin
      r_v1     <= bus.in_valid;
      r_hue    <= bus.in_phase + r_offset;
      r_mag1   <= bus.in_mag;
      r_last1  <= bus.in_valid & bus.in_last;

      r_v2     <= r_v1;
      r_red2   <= w_red;
      r_green2 <= w_green;
      r_blue2  <= w_blue;
      r_mag2   <= r_mag1;
      r_last2  <= r_last1;

      r_v3     <= r_v2;
      r_red3   <= scale(r_red2, r_mag2);
      r_green3 <= scale(r_green2, r_mag2);
      r_blue3  <= scale(r_blue2, r_mag2);
      r_last3  <= r_last2;
    end
  end

  assign bus.in_ready  = w_advance;
  assign bus.out_valid = r_v3;
  assign bus.out_red   = r_red3;
  assign bus.out_green = r_green3;
  assign bus.out_blue  = r_blue3;
  assign bus.out_last  = r_last3;

endmodule

`default_nettype wire

// File: tb/tb_phase_to_rgb_pipe.sv
// ============================================================================
// Module   : tb_phase_to_rgb_pipe
// Brief    : Randomised and directed self-checking bench with a behavioural colour model.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_phase_to_rgb_pipe;
  localparam int PW = 16;
  localparam int CW = 8;

  typedef struct {
    logic [24:0] px;
    int          cyc;
  } ent_t;

  logic clk;
  logic rst_n;

  phase_to_rgb_pipe_if #(.PHASE_W(PW), .COLOR_W(CW)) bus ();

  phase_to_rgb_pipe #(.PHASE_W(PW), .COLOR_W(CW), .OFFSET_RST(16'h8000)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          n_chk = 0;
  int          n_err = 0;
  int          cyc = 0;
  int          acc_cnt = 0;
  int          rdy_mode = 1;
  bit          chk_lat = 0;
  bit          rst_pend = 0;
  bit          stall_prev = 0;
  logic [25:0] held;
  logic [15:0] m_off = 16'h8000;
  ent_t        q[$];
  ent_t        seen[$];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s actual=%0h required=%0h at cycle %0d", nm, act, exp, cyc);
    end
  endtask

  // Hue wheel in plain integer arithmetic: 6 sectors of 2^16/6 phase each
  function automatic logic [23:0] model(input int ph, input int mg, input int off);
    int hue, p, sec, x, r, g, b;
    hue = (ph + off) % 65536;
    p   = hue * 6;
    sec = p / 65536;
    x   = (p % 65536) / 256;
    r = 0; g = 0; b = 0;
    case (sec)
      0: begin r = 255;     g = x;       b = 0;       end
      1: begin r = 255 - x; g = 255;     b = 0;       end
      2: begin r = 0;       g = 255;     b = x;       end
      3: begin r = 0;       g = 255 - x; b = 255;     end
      4: begin r = x;       g = 0;       b = 255;     end
      default: begin r = 255; g = 0;     b = 255 - x; end
    endcase
    return {8'(r * (mg + 1) / 256), 8'(g * (mg + 1) / 256), 8'(b * (mg + 1) / 256)};
  endfunction

  always @(posedge clk) begin
    #2;
    case (rdy_mode)
      0:       bus.out_ready = 1'b0;
      1:       bus.out_ready = 1'b1;
      default: bus.out_ready = 1'($urandom_range(0, 1));
    endcase
  end

  // Single compare process; every handshake seen here completes at the next rising edge
  always @(negedge clk) begin
    ent_t e;
    cyc++;
    if (rst_pend) begin
      chk("rst_out_valid", bus.out_valid, 0);
      chk("rst_rgb_last", {bus.out_red, bus.out_green, bus.out_blue, bus.out_last}, 0);
      rst_pend = 0;
    end
    chk("in_ready_rule", bus.in_ready, !bus.out_valid || bus.out_ready);
    if (stall_prev)
      chk("stall_hold", {bus.out_valid, bus.out_red, bus.out_green, bus.out_blue, bus.out_last}, held);
    stall_prev = 0;
    if (!rst_n) begin
      q.delete();
      m_off    = 16'h8000;
      rst_pend = 1;
    end else begin
      if (bus.out_valid && bus.out_ready) begin
        if (q.size() == 0) begin
          chk("output_without_input", q.size(), 1);
        end else begin
          e = q.pop_front();
          chk("pixel", {bus.out_red, bus.out_green, bus.out_blue, bus.out_last}, e.px);
          if (chk_lat) chk("latency", cyc - e.cyc, 3);
          seen.push_back('{px: {bus.out_red, bus.out_green, bus.out_blue, bus.out_last}, cyc: cyc});
        end
      end
      if (bus.in_valid && bus.in_ready) begin
        e.px  = {model(int'(bus.in_phase), int'(bus.in_mag), int'(m_off)), bus.in_last};
        e.cyc = cyc;
        q.push_back(e);
        acc_cnt++;
      end
      if (bus.offset_ld) m_off = bus.offset_in;
      if (bus.out_valid && !bus.out_ready) begin
        stall_prev = 1;
        held = {bus.out_valid, bus.out_red, bus.out_green, bus.out_blue, bus.out_last};
      end
    end
  end

  task automatic send(input logic [15:0] ph, input logic [7:0] mg, input logic lst,
                      input logic ld, input logic [15:0] off);
    int   n;
    logic acc;
    n = 0;
    acc = 0;
    bus.in_valid  = 1'b1;
    bus.in_phase  = ph;
    bus.in_mag    = mg;
    bus.in_last   = lst;
    bus.offset_ld = ld;
    bus.offset_in = off;
    while (!acc && n < 200) begin
      @(negedge clk);
      acc = bus.in_ready;
      @(posedge clk);
      #2;
      n++;
    end
    chk("send_accepted", acc, 1);
    bus.in_valid  = 1'b0;
    bus.in_last   = 1'b0;
    bus.offset_ld = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    rdy_mode = 1;
    while ((q.size() != 0 || bus.out_valid) && n < 500) begin
      @(posedge clk);
      #2;
      n++;
    end
    chk("drain_in_time", n < 500, 1);
  endtask

  localparam logic [24:0] RED    = {8'd255, 8'd0,   8'd0,   1'b0};
  localparam logic [24:0] YELLOW = {8'd255, 8'd255, 8'd0,   1'b0};
  localparam logic [24:0] CHART  = {8'd127, 8'd255, 8'd0,   1'b0};
  localparam logic [24:0] BLACK  = {8'd0,   8'd0,   8'd0,   1'b0};
  localparam logic [24:0] DRED   = {8'd127, 8'd0,   8'd0,   1'b0};
  localparam logic [24:0] CYAN   = {8'd0,   8'd255, 8'd255, 1'b0};

  initial begin
    int a0;
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_phase  = '0;
    bus.in_mag    = '0;
    bus.in_last   = 1'b0;
    bus.offset_in = '0;
    bus.offset_ld = 1'b0;
    bus.out_ready = 1'b1;

    chk("model_red",    model(16'h8000, 255, 16'h8000), 24'hFF0000);
    chk("model_yellow", model(16'hAAAB, 255, 16'h8000), 24'hFFFF00);
    chk("model_chart",  model(16'hC000, 255, 16'h8000), 24'h7FFF00);
    chk("model_wrap",   model(16'h7FFF, 255, 16'h8000), 24'hFF0000);
    chk("model_mag127", model(16'h8000, 127, 16'h8000), 24'h7F0000);

    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_in_ready", bus.in_ready, 1);
    chk("post_rst_out_valid", bus.out_valid, 0);
    @(posedge clk);
    #2;

    // Primary colours with fixed latency
    chk_lat = 1;
    seen.delete();
    send(16'h8000, 8'd255, 0, 0, 0);
    send(16'hAAAB, 8'd255, 0, 0, 0);
    send(16'hC000, 8'd255, 0, 0, 0);
    drain();
    chk("prim_count", seen.size(), 3);
    chk("prim_red",    seen[0].px, RED);
    chk("prim_yellow", seen[1].px, YELLOW);
    chk("prim_chart",  seen[2].px, CHART);

    seen.delete();
    send(16'h8000, 8'd0,   0, 0, 0);
    send(16'h8000, 8'd127, 0, 0, 0);
    send(16'h8000, 8'd255, 0, 0, 0);
    drain();
    chk("mag0",   seen[0].px, BLACK);
    chk("mag127", seen[1].px, DRED);
    chk("mag255", seen[2].px, RED);

    seen.delete();
    send(16'h0000, 8'd255, 0, 1, 16'h0000);
    send(16'h0000, 8'd255, 0, 0, 0);
    drain();
    chk("offset_old", seen[0].px, CYAN);
    chk("offset_new", seen[1].px, RED);
    send(16'h0000, 8'd255, 0, 1, 16'h8000);
    drain();

    // Backpressure: pipeline fills to 3 and holds
    chk_lat = 0;
    seen.delete();
    rdy_mode = 0;
    a0 = acc_cnt;
    fork
      begin
        for (int i = 0; i < 6; i++) send(16'(16'h8000 + i * 16'h1000), 8'd200, 0, 0, 0);
      end
    join_none
    repeat (6) @(posedge clk);
    #3;
    chk("bp_held_count", acc_cnt - a0, 3);
    chk("bp_in_ready_low", bus.in_ready, 0);
    rdy_mode = 1;
    wait fork;
    drain();
    chk("bp_out_count", seen.size(), 6);
    for (int i = 1; i < 6; i++) chk("bp_no_gap", seen[i].cyc - seen[0].cyc, i);

    seen.delete();
    rdy_mode = 2;
    for (int i = 0; i < 4; i++) send(16'($urandom), 8'($urandom), i == 3, 0, 0);
    drain();
    chk("frame_count", seen.size(), 4);
    for (int i = 0; i < 4; i++) chk("frame_last", seen[i].px[0], i == 3);

    // Mid-stream reset discards in-flight samples and the loaded offset
    chk_lat = 1;
    seen.delete();
    send(16'h4000, 8'd255, 0, 1, 16'h1234);
    send(16'h5000, 8'd200, 0, 0, 0);
    rst_n = 1'b0;
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    send(16'h8000, 8'd255, 0, 0, 0);
    drain();
    chk("rst_out_count", seen.size(), 1);
    chk("rst_offset_red", seen[0].px, RED);

    chk_lat = 0;
    rdy_mode = 2;
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk);
        #2;
      end
      send(16'($urandom), 8'($urandom), 1'($urandom_range(0, 1)),
           $urandom_range(0, 7) == 0, 16'($urandom));
    end
    drain();
    chk("queue_empty", q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout actual=%0d required=finish", cyc);
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
